// File: rtl/audio_pkg.sv
// Shared definitions for the audio output path: sample width, mute value,
// pacer FSM states and the shortest period the DAC serializer can sustain.
// No logic; constants and types only.
package audio_pkg;

    localparam int SAMPLE_W = 12;
    localparam logic [SAMPLE_W-1:0] MUTE_SAMPLE = 12'd0;

    // Serializer needs 34 clocks per frame; the pacer adds margin on top.
    localparam int MIN_DAC_PERIOD   = 34;
    localparam int MIN_PACER_PERIOD = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } pacer_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Sample FIFO: DEPTH x WIDTH storage with full/empty and occupancy level.
// Latency: a push is visible in o_level/o_rdata one cycle after the handshake.
// Backpressure: pushes while full and pops while empty are ignored internally.
// Ports: i_push/i_wdata write side, i_pop/o_rdata read side (show-ahead head),
//        o_full, o_empty, o_level (pointer difference, DEPTH representable).
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_level;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign o_level = w_level;
    assign o_full  = (w_level == FULL_LVL);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/sample_pacer.sv
// Paced sample source: releases one buffered PCM sample every PERIOD clocks
// as a one-cycle dac_valid strobe; sends silence and counts underruns when dry.
// Latency: first strobe PERIOD cycles after enable; in_ready = ~full (push any state).
// Ports: enable/in_* from producer, dac_din/dac_valid to serializer,
//        level/underrun_cnt/running status.
module sample_pacer
    import audio_pkg::*;
#(
    parameter int PERIOD      = 1134,
    parameter int DEPTH       = 16,
    parameter int PRIME_LEVEL = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [11:0]            in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [11:0]            dac_din,
    output logic                   dac_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             underrun_cnt,
    output logic                   running
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [15:0]   TICK_CNT  = 16'(PERIOD - 1);
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

    if (PERIOD < MIN_PACER_PERIOD || PERIOD <= MIN_DAC_PERIOD || PERIOD > 65535) begin : g_bad_period
        $error("sample_pacer: PERIOD out of range");
    end
    if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sample_pacer: DEPTH must be a power of two in 4..256");
    end
    if (PRIME_LEVEL < 1 || PRIME_LEVEL > DEPTH) begin : g_bad_prime
        $error("sample_pacer: PRIME_LEVEL must be in 1..DEPTH");
    end

    pacer_state_t  r_state;
    pacer_state_t  w_state_nxt;
    logic [15:0]   r_cnt;
    logic [15:0]   w_cnt_nxt;
    logic [11:0]   r_dac_din;
    logic [11:0]   w_din_nxt;
    logic          r_dac_valid;
    logic [7:0]    r_underrun_cnt;
    logic          r_running;

    logic          w_tick;
    logic          w_pulse;
    logic          w_pop;
    logic          w_underrun;
    logic          w_push;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [11:0]   w_fifo_rdata;
    logic [LW-1:0] w_level;

    assign w_push       = in_valid & ~w_fifo_full;
    assign in_ready     = ~w_fifo_full;
    assign level        = w_level;
    assign dac_din      = r_dac_din;
    assign dac_valid    = r_dac_valid;
    assign underrun_cnt = r_underrun_cnt;
    assign running      = r_running;

    // Tick is suppressed in the same cycle enable drops, so no stray strobe.
    assign w_tick = enable && (r_state != IDLE) && (r_cnt == TICK_CNT);

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (in_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_level)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_din_nxt   = r_dac_din;
        w_pulse     = 1'b0;
        w_pop       = 1'b0;
        w_underrun  = 1'b0;
        if (!enable) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            // Counter stays at 0 on the IDLE->PRIME edge so the first tick
            // lands exactly PERIOD cycles after enable is seen.
            if (r_state == IDLE || w_tick) w_cnt_nxt = '0;
            else                           w_cnt_nxt = r_cnt + 16'd1;
            case (r_state)
                IDLE: w_state_nxt = PRIME;
                PRIME: begin
                    if (w_tick) begin
                        w_pulse   = 1'b1;
                        w_din_nxt = MUTE_SAMPLE;
                        if (w_level >= PRIME_LVL) w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (w_tick) begin
                        w_pulse = 1'b1;
                        if (!w_fifo_empty) begin
                            w_pop     = 1'b1;
                            w_din_nxt = w_fifo_rdata;
                        end else begin
                            w_underrun  = 1'b1;
                            w_din_nxt   = MUTE_SAMPLE;
                            w_state_nxt = PRIME;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_dac_din      <= MUTE_SAMPLE;
            r_dac_valid    <= 1'b0;
            r_underrun_cnt <= '0;
            r_running      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dac_din   <= w_din_nxt;
            r_dac_valid <= w_pulse;
            r_running   <= (w_state_nxt == RUN);
            if (w_underrun && r_underrun_cnt != 8'hFF)
                r_underrun_cnt <= r_underrun_cnt + 8'd1;
        end
    end

endmodule
